// File: rtl/rll_key_loader.sv
// Bit-serial loader for the 32-bit unlock key of a random-logic-locked core; the key reaches the core only after a complete load.
// Optional odd-parity check over key+parity bit is enabled by defining RLL_KEY_PARITY_EN.
module rll_key_loader #(
  parameter int                   KEY_WIDTH = 32,
  parameter logic [KEY_WIDTH-1:0] RESET_KEY = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 ser_valid,
  input  logic                 ser_data,
  output logic                 ser_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 key_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam int CNT_W = $clog2(KEY_WIDTH + 1);
`ifdef RLL_KEY_PARITY_EN
  localparam int N = KEY_WIDTH + 1;
`else
  localparam int N = KEY_WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0] sh_q, sh_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 key_valid_q, key_valid_d;
`ifdef RLL_KEY_PARITY_EN
  logic                 par_q, par_d;
  logic                 key_err_q, key_err_d;
  logic                 parity_ok;

  // Odd parity across the key bits and the parity bit marks a good load.
  assign parity_ok = ^{sh_q, par_q};
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case below can leave a variable unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
`ifdef RLL_KEY_PARITY_EN
    par_d       = par_q;
    key_err_d   = key_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
`ifdef RLL_KEY_PARITY_EN
          key_err_d = 1'b0;
`endif
        end
      end

      SHIFT: begin
        // A restart takes priority over a bit offered in the same cycle.
        if (load_start) begin
          cnt_d = '0;
        end else if (ser_valid) begin
          for (int i = 0; i < KEY_WIDTH; i++) begin
            if (cnt_q == CNT_W'(i)) sh_d[i] = ser_data;
          end
`ifdef RLL_KEY_PARITY_EN
          if (cnt_q == CNT_W'(KEY_WIDTH)) par_d = ser_data;
`endif
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) state_d = CHECK;
        end
      end

      CHECK: begin
        state_d = IDLE;
`ifdef RLL_KEY_PARITY_EN
        if (parity_ok) begin
          key_d       = sh_q;
          key_valid_d = 1'b1;
          key_err_d   = 1'b0;
        end else begin
          key_d       = RESET_KEY;
          key_valid_d = 1'b0;
          key_err_d   = 1'b1;
        end
`else
        key_d       = sh_q;
        key_valid_d = 1'b1;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      key_q       <= RESET_KEY;
      key_valid_q <= 1'b0;
`ifdef RLL_KEY_PARITY_EN
      par_q       <= 1'b0;
      key_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
`ifdef RLL_KEY_PARITY_EN
      par_q       <= par_d;
      key_err_q   <= key_err_d;
`endif
    end
  end

  assign ser_ready = (state_q == SHIFT);
  assign busy      = (state_q != IDLE);
  assign key_out   = key_q;
  assign key_valid = key_valid_q;
`ifdef RLL_KEY_PARITY_EN
  assign key_err   = key_err_q;
`else
  assign key_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed self-checking bench for rll_key_loader; expectations adapt to whether RLL_KEY_PARITY_EN is defined.
module tb_rll_key_loader;

`ifdef RLL_KEY_PARITY_EN
  localparam int N      = 33;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int N      = 32;
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, load_start, ser_valid, ser_data;
  logic        ser_ready, key_valid, key_err, busy;
  logic [31:0] key_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int cyc_e;
  logic [31:0] exp_key;
  logic        exp_valid, exp_err;
  logic [32:0] word;

  rll_key_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .ser_valid  (ser_valid),
    .ser_data   (ser_data),
    .ser_ready  (ser_ready),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .key_err    (key_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_load;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
  endtask

  task automatic send(input logic [32:0] w, input int nbits, input bit stall);
    for (int i = 0; i < nbits; i++) begin
      if (stall) begin
        ser_valid = 1'b0;
        ser_data  = 1'($urandom_range(0, 1));
        tick;
      end
      ser_valid = 1'b1;
      ser_data  = w[i];
      tick;
    end
    ser_valid = 1'b0;
    ser_data  = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick;
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_out"},   key_out,   32'h0);
    check({tag, "_key_valid"}, key_valid, 0);
    check({tag, "_key_err"},   key_err,   0);
    check({tag, "_ser_ready"}, ser_ready, 0);
    check({tag, "_busy"},      busy,      0);
  endtask

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    tick;
    tick;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick;

    // Good load with continuous valid; commit must land N+1 edges after load_start.
    start_load;
    cyc_e = cyc;
    check("good_ready", ser_ready, 1);
    check("good_busy",  busy,      1);
    send({1'b1, 32'hA5C3_0F96}, N, 1'b0);
    check("good_check_no_commit", key_valid, 0);
    check("good_check_busy",      busy,      1);
    check("good_check_ready",     ser_ready, 0);
    wait_idle;
    check("good_latency",   cyc - cyc_e, N + 1);
    check("good_key_out",   key_out,   32'hA5C3_0F96);
    check("good_key_valid", key_valid, 1);
    check("good_key_err",   key_err,   0);
    check("good_ready_off", ser_ready, 0);

    // Bad parity load: committed key holds through SHIFT and CHECK.
    word = {1'b1, 32'h0000_0001};
    start_load;
    send(word, 5, 1'b0);
    check("bad_mid_key_out",   key_out,   32'hA5C3_0F96);
    check("bad_mid_key_valid", key_valid, 1);
    send(word >> 5, N - 5, 1'b0);
    check("bad_check_key_out", key_out, 32'hA5C3_0F96);
    wait_idle;
    exp_key   = PAR_EN ? 32'h0 : 32'h0000_0001;
    exp_valid = !PAR_EN;
    exp_err   = PAR_EN;
    check("bad_key_out",   key_out,   exp_key);
    check("bad_key_valid", key_valid, exp_valid);
    check("bad_key_err",   key_err,   exp_err);

    // Restart after 10 bits; a bit offered with the restart pulse is dropped.
    start_load;
    send(33'h0, 10, 1'b0);
    check("restart_key_hold", key_out, exp_key);
    load_start = 1'b1;
    ser_valid  = 1'b1;
    ser_data   = 1'b0;
    tick;
    load_start = 1'b0;
    ser_valid  = 1'b0;
    check("restart_ready", ser_ready, 1);
    check("restart_busy",  busy,      1);
    check("restart_key_valid_hold", key_valid, exp_valid);
    send({1'b1, 32'hFFFF_FFFF}, N, 1'b0);
    wait_idle;
    check("restart_key_out",   key_out,   32'hFFFF_FFFF);
    check("restart_key_valid", key_valid, 1);
    check("restart_key_err",   key_err,   0);

    // Same good key with ser_valid toggling and random data in the gaps.
    start_load;
    send({1'b1, 32'hA5C3_0F96}, N, 1'b1);
    wait_idle;
    check("stall_key_out",   key_out,   32'hA5C3_0F96);
    check("stall_key_valid", key_valid, 1);
    check("stall_key_err",   key_err,   0);

    // Reset after 20 bits drops the committed key, then a fresh load works.
    start_load;
    send({1'b0, 32'h1234_5678}, 20, 1'b0);
    rst = 1'b1;
    tick;
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick;
    start_load;
    send({1'b1, 32'h0F0F_0F0F}, N, 1'b0);
    wait_idle;
    check("fresh_key_out",   key_out,   32'h0F0F_0F0F);
    check("fresh_key_valid", key_valid, 1);
    check("fresh_key_err",   key_err,   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rll_key_loader.md
# rll_key_loader

Serial key loader that delivers the 32-bit unlock key to a random-logic-locked netlist. It drives the `keyIn_0_0..keyIn_0_31` inputs of the locked core. It accepts the key bit-serially over a valid/ready handshake and optionally checks a parity bit. The key is committed to the core only after a complete, error-free load. Until then, and after any failed load, the core sees a fixed non-unlocking key.

## Interface
Parameters:
- `KEY_WIDTH`, 32: number of key bits; equals the locked core's key input count.
- `RESET_KEY`, 32'h0000_0000: value driven on `key_out` when no valid key is committed.

Ports:
- `clk`  in  1: single clock. All state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `load_start`  in  1: one-cycle pulse that begins a new load.
- `ser_valid`  in  1: a serial bit is presented on `ser_data`.
- `ser_data`  in  1: serial key bit, LSB (keyIn_0_0) first.
- `ser_ready`  out  1: loader accepts a bit this cycle.
- `key_out`  out  KEY_WIDTH: bit i drives `keyIn_0_i` of the locked core.
- `key_valid`  out  1: `key_out` holds a committed, checked key.
- `key_err`  out  1: the last load failed the parity check.
- `busy`  out  1: a load is in progress (SHIFT or CHECK).

## Operation
- States: IDLE, SHIFT, CHECK.
- Counter `cnt` is $clog2(KEY_WIDTH+1) bits wide. Shift register `sh` is KEY_WIDTH bits, plus a parity flop when parity is enabled.
- IDLE:
  - `ser_ready`=0.
  - `load_start`=1 → SHIFT; `cnt`←0; `key_err`←0.
  - `key_out`/`key_valid` retain their previous values.
- SHIFT:
  - `ser_ready`=1.
  - Accept a bit when `ser_valid && ser_ready`: `sh[cnt]`←`ser_data`; `cnt`←`cnt`+1.
  - The state is left on accepting bit index N-1, where N = KEY_WIDTH (+1 with parity). SHIFT → CHECK.
  - The parity bit is the last bit accepted.
- CHECK (exactly one cycle):
  - `ser_ready`=0.
  - Pass: `key_out`←`sh`; `key_valid`←1; `key_err`←0.
  - Fail: `key_out`←RESET_KEY; `key_valid`←0; `key_err`←1.
  - Then → IDLE.
- Parity rule: XOR of the KEY_WIDTH key bits XOR the parity bit must equal 1 (odd parity over N bits).
- `load_start` in SHIFT: restart. `cnt`←0, bits already shifted are discarded, state stays SHIFT. `key_out`/`key_valid` are unchanged.
- `load_start` in CHECK: ignored. The CHECK result is applied.
- `load_start` in the same cycle as a bit accept in SHIFT: restart wins and the bit is dropped.
- A new load does not disturb the committed key until its own CHECK cycle.
- `busy` = (state != IDLE).

## Timing
- Reset values: state=IDLE, `cnt`=0, `sh`=0, `key_out`=RESET_KEY, `key_valid`=0, `key_err`=0, `ser_ready`=0, `busy`=0.
- `rst` mid-load aborts immediately. All registers return to their reset values on that edge, including a previously committed key.
- `ser_ready` and `busy` are decoded from registered state and have no combinational path from inputs.
- Latency:
  - `load_start` sampled at edge E → SHIFT and `ser_ready`=1 from E+1.
  - Final bit accepted at edge F → CHECK during F..F+1.
  - `key_out`/`key_valid`/`key_err` update at edge F+1.
- Minimum load duration: 1 + N + 1 cycles with back-to-back `ser_valid`.
- `ser_valid` gaps are allowed without limit. There is no timeout.
- `ser_data` is ignored when no bit is accepted.

## Configuration
- Macro: `RLL_KEY_PARITY_EN`.
- Defined: N = KEY_WIDTH+1. The odd-parity bit follows the key bits, and CHECK can fail.
- Undefined:
  - N = KEY_WIDTH, with no parity flop.
  - CHECK always passes and `key_err` is tied to 0.
  - All other timing is identical.

## Test plan
- Reset: assert `rst` for 2 cycles → `key_out`=0x00000000, `key_valid`=0, `key_err`=0, `ser_ready`=0, `busy`=0.
- Good load, parity on:
  - Stimulus: `load_start`, then key 0xA5C3_0F96 LSB-first with parity bit 1 (key has 16 ones), `ser_valid` continuous.
  - Response: `key_out`=0xA5C30F96 and `key_valid`=1 exactly 34 cycles after the `load_start` edge; `busy` drops on the same edge.
- Bad parity:
  - Stimulus: after the good load, reload 0x0000_0001 with parity bit 1.
  - Response: `key_out` stays 0xA5C30F96 through SHIFT; at the CHECK edge it becomes 0x00000000 with `key_valid`=0 and `key_err`=1.
- Restart mid-load: shift 10 bits, pulse `load_start`, then shift 0xFFFF_FFFF with parity 1 → `key_out`=0xFFFFFFFF. The first 10 bits have no effect.
- Stalls: same 0xA5C30F96 load with `ser_valid` toggling 1/0 every cycle → identical final key. `cnt` only advances on accepted bits.
- Reset mid-load: assert `rst` after 20 bits of a load that follows a committed key → all outputs at reset values on the next edge, then a fresh load succeeds.
